// File: rtl/sid_reg_writer.sv
// Replays timed {addr, data, delay} commands as single-cycle SID register write strobes.
// Latency: a push reaches the holding register two clk later; the strobe follows the (delay+1)th clkEn tick by one clk.
// Backpressure: oReady drops when the command FIFO holds DEPTH entries or while iFlush is asserted.
module sid_reg_writer #(
    parameter int DEPTH   = 16,
    parameter int DELAY_W = 16
) (
    input  logic                     clk,
    input  logic                     iRstN,
    input  logic                     clkEn,
    input  logic                     iValid,
    output logic                     oReady,
    input  logic [4:0]               iAddr,
    input  logic [7:0]               iData,
    input  logic [DELAY_W-1:0]       iDelay,
    input  logic                     iFlush,
    output logic                     oWE,
    output logic [4:0]               oAddr,
    output logic [7:0]               oData,
    output logic                     oBusy,
    output logic [$clog2(DEPTH):0]   oCount
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]        PTR_ONE = (AW+1)'(1);
    localparam logic [DELAY_W-1:0] CNT_ONE = DELAY_W'(1);

    typedef struct packed {
        logic [4:0]         addr;
        logic [7:0]         data;
        logic [DELAY_W-1:0] delay;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ISSUE = 2'd2
    } state_t;

    cmd_t   fifoMem [DEPTH];
    cmd_t   pushCmd;
    cmd_t   hold;
    logic [AW:0] wrPtr;
    logic [AW:0] rdPtr;
    state_t state;
    state_t stateNext;
    logic   fifoEmpty;
    logic   fifoFull;
    logic   doPush;
    logic   doPop;
    logic   decCnt;

    // The extra pointer MSB separates a full FIFO from an empty one when the index bits match.
    assign fifoEmpty = (wrPtr == rdPtr);
    assign fifoFull  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign oReady    = !fifoFull && !iFlush;
    assign doPush    = iValid && oReady;
    assign oCount    = wrPtr - rdPtr;
    assign oBusy     = (state != IDLE) || !fifoEmpty;
    assign pushCmd   = {iAddr, iData, iDelay};

    // Command storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (doPush) begin
            fifoMem[wrPtr[AW-1:0]] <= pushCmd;
        end
    end

    // FIFO pointers; flush overrides any push or pop in the same cycle.
    always_ff @(posedge clk) begin
        if (!iRstN || iFlush) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + PTR_ONE;
            end
            if (doPop) begin
                rdPtr <= rdPtr + PTR_ONE;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!iRstN) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state: IDLE ignores clkEn, WAIT counts ticks, ISSUE lasts one clk and may chain straight into WAIT.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (!iFlush && !fifoEmpty) begin
                    stateNext = WAIT;
                end
            end
            WAIT: begin
                if (iFlush) begin
                    stateNext = IDLE;
                end else if (clkEn && (hold.delay == '0)) begin
                    stateNext = ISSUE;
                end
            end
            ISSUE: begin
                if (!iFlush && !fifoEmpty) begin
                    stateNext = WAIT;
                end else begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // FSM control outputs: when to pop the FIFO head and when to count down the delay.
    always_comb begin
        doPop  = 1'b0;
        decCnt = 1'b0;
        case (state)
            IDLE:    doPop  = !iFlush && !fifoEmpty;
            WAIT:    decCnt = !iFlush && clkEn && (hold.delay != '0);
            ISSUE:   doPop  = !iFlush && !fifoEmpty;
            default: begin
                doPop  = 1'b0;
                decCnt = 1'b0;
            end
        endcase
    end

    // Holding register; the counter stops at zero so it can never wrap.
    always_ff @(posedge clk) begin
        if (!iRstN) begin
            hold <= '0;
        end else if (doPop) begin
            hold <= fifoMem[rdPtr[AW-1:0]];
        end else if (decCnt) begin
            hold.delay <= hold.delay - CNT_ONE;
        end
    end

    // Registered bus outputs; address/data only change on entry to ISSUE.
    always_ff @(posedge clk) begin
        if (!iRstN) begin
            oWE   <= 1'b0;
            oAddr <= '0;
            oData <= '0;
        end else begin
            oWE <= (stateNext == ISSUE);
            if (stateNext == ISSUE) begin
                oAddr <= hold.addr;
                oData <= hold.data;
            end
        end
    end

endmodule

// File: tb/tb_sid_reg_writer.sv
// Bench for sid_reg_writer: random and directed timed command streams scored against a tick-counting reference.
// Latency: expected strobe cycle derived from push cycle, previous strobe and the clkEn history.
// Backpressure: pushes hold iValid until oReady is seen, bounded by a cycle budget.
module tb_sid_reg_writer;

    localparam int DEPTH = 16;
    localparam int DW    = 4;

    logic          clk = 1'b0;
    logic          iRstN = 1'b0;
    logic          clkEn = 1'b0;
    logic          iValid = 1'b0;
    logic          oReady;
    logic [4:0]    iAddr = '0;
    logic [7:0]    iData = '0;
    logic [DW-1:0] iDelay = '0;
    logic          iFlush = 1'b0;
    logic          oWE;
    logic [4:0]    oAddr;
    logic [7:0]    oData;
    logic          oBusy;
    logic [4:0]    oCount;

    sid_reg_writer #(.DEPTH(DEPTH), .DELAY_W(DW)) dut (
        .clk(clk), .iRstN(iRstN), .clkEn(clkEn), .iValid(iValid), .oReady(oReady),
        .iAddr(iAddr), .iData(iData), .iDelay(iDelay), .iFlush(iFlush),
        .oWE(oWE), .oAddr(oAddr), .oData(oData), .oBusy(oBusy), .oCount(oCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] a;
        logic [7:0] d;
        int         dly;
        int         p;
    } ent_t;

    ent_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   lastI = -10;
    int   ceMode = 0;
    bit   ceShot = 1'b0;
    bit   ceLog [0:65535];
    bit   prevWE = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // clkEn source: periodic when ceMode > 0, otherwise low except for requested single shots.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ceShot) begin
                clkEn = 1'b1;
                ceShot = 1'b0;
            end else begin
                clkEn = (ceMode > 0) && (cyc % ceMode == 0);
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: record clkEn history and score every strobe on content and timing.
    always @(negedge clk) begin
        ent_t e;
        int   s;
        int   ticks;
        int   expI;
        if (cyc < 65536) ceLog[cyc] = clkEn;
        if (oWE) begin
            chk("we_single_cycle", int'(prevWE), 0);
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe actual=addr %0h data %0h required=none (cycle %0d)", oAddr, oData, cyc);
            end else begin
                e = q.pop_front();
                chk("strobe_addr", int'(oAddr), int'(e.a));
                chk("strobe_data", int'(oData), int'(e.d));
                // Command starts waiting two clk after its push, or the clk after the previous strobe.
                s = (e.p + 2 > lastI + 1) ? e.p + 2 : lastI + 1;
                ticks = 0;
                expI = -1;
                for (int c = s; c < cyc && expI < 0; c++) begin
                    if (ceLog[c]) begin
                        ticks++;
                        if (ticks == e.dly + 1) expI = c + 1;
                    end
                end
                chk("strobe_cycle", cyc, expI);
            end
            lastI = cyc;
        end
        prevWE = oWE;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called just after a rising edge; holds the command until accepted.
    task automatic push(input logic [4:0] a, input logic [7:0] d, input int dly);
        int n = 0;
        bit done = 1'b0;
        iValid = 1'b1;
        iAddr  = a;
        iData  = d;
        iDelay = DW'(dly);
        while (!done && n < 300) begin
            @(negedge clk);
            if (oReady) begin
                q.push_back('{a: a, d: d, dly: dly, p: cyc});
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            n++;
        end
        iValid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL push_timeout actual=not accepted required=accepted (cycle %0d)", cyc);
        end
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while (q.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout actual=%0d pending required=0", q.size());
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        step(3);
        @(negedge clk);
        chk("rst_we", int'(oWE), 0);
        chk("rst_addr", int'(oAddr), 0);
        chk("rst_busy", int'(oBusy), 0);
        chk("rst_count", int'(oCount), 0);
        chk("rst_ready", int'(oReady), 1);
        @(posedge clk);
        #1;
        iRstN = 1'b1;
        lastI = cyc;

        // Single zero-delay command with a slow tick.
        ceMode = 16;
        push(5'h04, 8'h41, 0);
        drain(400);
        @(negedge clk);
        chk("t1_busy_after", int'(oBusy), 0);
        chk("t1_addr_hold", int'(oAddr), 5'h04);
        chk("t1_data_hold", int'(oData), 8'h41);
        step(1);

        // Two commands, the second chained behind the first.
        ceMode = 6;
        push(5'h00, 8'h12, 3);
        push(5'h01, 8'h34, 0);
        drain(400);
        step(2);

        // Fill with clkEn low twice to exercise full flag and pointer wrap.
        for (int f = 0; f < 2; f++) begin
            ceMode = 0;
            step(2);
            for (int i = 0; i < DEPTH + 1; i++) push(5'(i), 8'(f * 32 + i), $urandom_range(0, 15));
            iValid = 1'b1;
            iAddr  = 5'h1e;
            iData  = 8'hee;
            iDelay = '0;
            @(negedge clk);
            chk("full_count", int'(oCount), DEPTH);
            chk("full_ready", int'(oReady), 0);
            step(3);
            @(negedge clk);
            chk("full_ready_held", int'(oReady), 0);
            step(1);
            iValid = 1'b0;
            ceMode = 4 + f;
            drain(2000);
            @(negedge clk);
            chk("full_drained_count", int'(oCount), 0);
            step(1);
        end

        // Flush while waiting with cnt=2.
        ceMode = 0;
        step(2);
        for (int i = 0; i < 5; i++) push(5'(8 + i), 8'(8'h50 + i), 5);
        step(2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ceShot = 1'b1;
            @(negedge clk);
            @(negedge clk);
        end
        step(2);
        iFlush = 1'b1;
        iValid = 1'b1;
        @(negedge clk);
        chk("flush_ready", int'(oReady), 0);
        q.delete();
        lastI = cyc;
        step(1);
        iFlush = 1'b0;
        iValid = 1'b0;
        @(negedge clk);
        chk("flush_count", int'(oCount), 0);
        chk("flush_busy", int'(oBusy), 0);
        step(1);
        ceMode = 5;
        step(60);
        push(5'h1f, 8'h99, 1);
        drain(300);
        step(2);

        // Reset during WAIT with three commands queued.
        ceMode = 0;
        step(2);
        for (int i = 0; i < 3; i++) push(5'(i + 3), 8'(8'h70 + i), 10);
        step(2);
        iRstN = 1'b0;
        step(1);
        iRstN = 1'b1;
        @(negedge clk);
        q.delete();
        lastI = cyc;
        chk("rst2_we", int'(oWE), 0);
        chk("rst2_addr", int'(oAddr), 0);
        chk("rst2_data", int'(oData), 0);
        chk("rst2_busy", int'(oBusy), 0);
        chk("rst2_count", int'(oCount), 0);
        step(1);
        ceMode = 4;
        step(80);

        // Push coinciding with a pop at occupancy 4.
        ceMode = 0;
        step(2);
        for (int i = 0; i < 5; i++) push(5'(i + 16), 8'(8'ha0 + i), 0);
        step(2);
        @(negedge clk);
        chk("simul_count_before", int'(oCount), 4);
        ceShot = 1'b1;
        step(1);
        step(1);
        push(5'h15, 8'hb5, 2);
        @(negedge clk);
        chk("simul_count_after", int'(oCount), 4);
        step(1);
        ceMode = 3;
        drain(400);
        step(2);

        // Random traffic, including all-ones delays.
        ceMode = $urandom_range(3, 8);
        for (int i = 0; i < 40; i++) begin
            int dly;
            dly = (i % 7 == 0) ? 15 : $urandom_range(0, 15);
            push(5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)), dly);
            step($urandom_range(0, 3));
        end
        drain(8000);
        @(negedge clk);
        chk("final_busy", int'(oBusy), 0);
        chk("final_count", int'(oCount), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
